iter_multiplier: RTL
====================

Name: iter_multiplier

Overview:
- Parametrised iterative shift-add multiplier for the RV32M execute stage; successor to the fully parallel 32-row shift_block array.
- Retires BITS_PER_CYC multiplier bits per cycle, so area and latency trade off through one parameter.
- Supports all four RV32M multiply ops (MUL/MULH/MULHSU/MULHU).
- Uses valid/ready on both input and output so the pipeline can stall on it, plus a flush input for branch/exception kill.

Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYC, 1, multiplier bits consumed per cycle. Legal values: 1, 2, 4, 8; must divide XLEN.
- N (localparam), XLEN/BITS_PER_CYC, iteration count.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RSTn  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept.
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- flush  in  1  abort any operation in flight.
- out_valid  out  1  res is valid.
- out_ready  in  1  consumer takes res.
- res  out  XLEN  selected product half.
- busy  out  1  high in RUN or DONE.

Behaviour:
- **Reset.** While RSTn is low at a clock edge:
  - state goes to IDLE;
  - in_ready=1, out_valid=0, busy=0, res=0;
  - accumulator, counter and sign flag go to 0.
  - A reset mid-operation discards the operation; nothing is emitted.
- **States.** IDLE, RUN, DONE.
- **IDLE.**
  - in_ready=1.
  - Accept occurs when in_valid=1 and flush=0. On the accept edge, capture:
    - mag_a = |in_a| if op is MULH or MULHSU and in_a[XLEN-1]=1, else in_a;
    - mag_b = |in_b| if op is MULH and in_b[XLEN-1]=1, else in_b;
    - neg = sign_a XOR sign_b, using the signed flags above;
    - hi_sel = (op != MUL);
    - acc (2*XLEN) = 0; cnt = 0.
  - Then go to RUN.
- **RUN.**
  - Each cycle: acc += (mag_a * mag_b[BITS_PER_CYC-1:0]) << (cnt*BITS_PER_CYC); mag_b shifts right by BITS_PER_CYC; cnt++.
  - After N RUN cycles (cnt==N-1 on that edge), go to DONE.
  - On the DONE entry edge, register res = hi_sel ? P[2X-1:X] : P[X-1:0], where P = neg ? -acc : acc (2*XLEN two's complement).
- **DONE.**
  - out_valid=1; res is stable until handshake.
  - When out_ready=1, go to IDLE on that edge. No same-cycle accept: in_ready=0 in DONE.
- **Latency.** The first out_valid=1 cycle is exactly N+1 cycles after the accept edge (N=32 gives 33).
  - Throughput is one op per N+2 cycles with out_ready held high.
- **Width rules.**
  - mag of -2^(XLEN-1) is 2^(XLEN-1), representable unsigned; no overflow.
  - The accumulator is 2*XLEN bits and never carries out.
- **Flush.**
  - In RUN or DONE, flush=1 returns to IDLE on the next edge with out_valid=0; the result is dropped.
  - flush has priority over out_ready and over in_valid in IDLE (no accept).
- **Operand stability.** in_valid/in_a/in_b/op are ignored outside IDLE; operands changing during RUN do not affect the result.
- **Zero operands.** No early termination; latency is constant.

Decomposition:
- mul_pkg holds:
  - op encodings MUL_OP_MUL=2'b00, MUL_OP_MULH=2'b01, MUL_OP_MULHSU=2'b10, MUL_OP_MULHU=2'b11;
  - state encoding IDLE/RUN/DONE.
- One sub-module, mul_step: combinational partial product of XLEN x BITS_PER_CYC, shifted and added into the 2*XLEN accumulator.
  - Instantiated once; replaces the 32-instance parallel array.
- FSM, counter, sign fix-up and handshake stay in iter_multiplier.

Test Plan:
1. BITS_PER_CYC=1, MUL 7 x 6 with out_ready=1 -> res=42, out_valid high exactly 33 cycles after the accept edge for one cycle, then in_ready=1.
2. MULH 0x80000000 x 0x80000000 -> res=0x40000000; MUL same operands -> res=0x00000000.
3. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> res=0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
4. Backpressure: MUL 3 x 5 with out_ready=0 for 5 cycles after out_valid -> res=15 held stable; in_valid pulsed during RUN/DONE is ignored (in_ready=0); handshake then returns to IDLE.
5. Abort: flush at RUN cycle 10 -> no out_valid, in_ready=1 next cycle, next op MUL 2 x 2 -> 4. Separately, RSTn=0 mid-RUN -> res=0, out_valid=0, busy=0 after that edge.
6. BITS_PER_CYC=4: MUL 0xFFFFFFFD x 5 -> res=0xFFFFFFF1, latency 9 cycles; also run a randomised 1000-op sweep against a 64-bit reference model for all four ops.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared encodings for the iterative RV32M multiplier.
package mul_pkg;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: XLEN x BITS_PER_CYC partial product added into the accumulator.
module mul_step #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BITS_PER_CYC = 1,
    parameter int unsigned CW           = 5
) (
    input  logic [XLEN-1:0]         mag_a,
    input  logic [BITS_PER_CYC-1:0] b_bits,
    input  logic [CW-1:0]           cnt,
    input  logic [2*XLEN-1:0]       acc_in,
    output logic [2*XLEN-1:0]       acc_out
);

    localparam int unsigned PW = XLEN + BITS_PER_CYC;
    localparam int unsigned SW = $clog2(2 * XLEN);

    logic [PW-1:0] pp;
    logic [SW-1:0] shamt;

    // Shift never exceeds XLEN-BITS_PER_CYC, so the shifted product always fits in 2*XLEN.
    always_comb begin
        pp      = PW'(mag_a) * PW'(b_bits);
        shamt   = SW'(cnt) * SW'(BITS_PER_CYC);
        acc_out = acc_in + ((2 * XLEN)'(pp) << shamt);
    end

endmodule

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU with valid/ready and flush.
module iter_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BITS_PER_CYC = 1
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            busy
);

    localparam int unsigned N  = XLEN / BITS_PER_CYC;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    mul_state_e        state;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg;
    logic              hi_sel;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;

    logic              sign_a;
    logic              sign_b;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;

    // Operand signedness by op, and sign fix-up of the final accumulator.
    always_comb begin
        sign_a = ((op == MUL_OP_MULH) || (op == MUL_OP_MULHSU)) && in_a[XLEN-1];
        sign_b = (op == MUL_OP_MULH) && in_b[XLEN-1];
        prod   = neg ? -acc_next : acc_next;
    end

    mul_step #(
        .XLEN        (XLEN),
        .BITS_PER_CYC(BITS_PER_CYC),
        .CW          (CW)
    ) u_step (
        .mag_a  (mag_a),
        .b_bits (mag_b[BITS_PER_CYC-1:0]),
        .cnt    (cnt),
        .acc_in (acc),
        .acc_out(acc_next)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            res       <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            hi_sel    <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        mag_a    <= sign_a ? -in_a : in_a;
                        mag_b    <= sign_b ? -in_b : in_b;
                        neg      <= sign_a ^ sign_b;
                        hi_sel   <= (op != MUL_OP_MUL);
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        acc   <= acc_next;
                        mag_b <= mag_b >> BITS_PER_CYC;
                        cnt   <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            res       <= hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                        end
                    end
                end
                DONE: begin
                    // flush and a taken result both end the operation; flush just drops it
                    if (flush || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
